// File: rtl/pwm_gen_n_pkg.sv
// Shared defaults, dead-time state encoding and parameter helpers for the
// N-channel PWM generator.
package pwm_gen_n_pkg;

   localparam int N_DEF      = 3;
   localparam int W_DEF      = 9;
   localparam int PERIOD_DEF = 510;
   localparam int DT_DEF     = 4;

   typedef enum logic [1:0] {
      DT_IDLE,
      DT_WAIT,
      DT_DRIVE
   } dt_state_e;

   function automatic int clog2(input int v);
      for (int r = 0; r < 31; r++) begin
         if ((1 << r) >= v) return r;
      end
      return 31;
   endfunction

   // Dead-time counter must hold DT itself; never narrower than one bit.
   function automatic int dt_width(input int dt);
      int w;
      w = clog2(dt + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit period_ok(input int period, input int w);
      return (period >= 2) && (period <= (1 << w));
   endfunction

   function automatic bit dt_ok(input int dt, input int period);
      return (dt >= 0) && (dt < period / 2);
   endfunction

endpackage

// File: rtl/pwm_gen_n_if.sv
// Control/status bundle between the PWM block and its host.
interface pwm_gen_n_if import pwm_gen_n_pkg::*; #(
   parameter int N = N_DEF,
   parameter int W = W_DEF
);
   logic           E;
   logic           LD;
   logic [N*W-1:0] D;
   logic [N-1:0]   PH;
   logic [N-1:0]   PL;
   logic [N-1:0]   X;
   logic           PS;
   logic [W-1:0]   CNT;

   modport master (output E, LD, D, input PH, PL, X, PS, CNT);
   modport slave  (input E, LD, D, output PH, PL, X, PS, CNT);
endinterface

// File: rtl/pwm_gen_n_deadtime.sv
// Per-channel complementary gate driver with dead-time insertion.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DT_IDLE  | disabled; both gates off, waiting for E
// DT_WAIT  | both gates off, counting DT down after a cmd change/start
// DT_DRIVE | gate matching the held cmd is on
module pwm_gen_n_deadtime import pwm_gen_n_pkg::*; #(
   parameter int DT = DT_DEF
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic E,
   input  logic CMD,
   output logic PH,
   output logic PL
);

   if (DT == 0) begin : g_nodt
      // No dead time: gates follow cmd one cycle late.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            PH <= 1'b0;
            PL <= 1'b0;
         end else if (!E) begin
            PH <= 1'b0;
            PL <= 1'b0;
         end else begin
            PH <= CMD;
            PL <= ~CMD;
         end
      end
   end else begin : g_dt
      localparam int DTW = dt_width(DT);
      localparam logic [DTW-1:0] DT_LOAD = DTW'(DT);

      dt_state_e      state;
      logic [DTW-1:0] dt_cnt;
      logic           cmd_q;

      // The gate turns on on the edge that retires the last dead-time count,
      // so exactly DT both-off cycles separate the two sides.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            state  <= DT_IDLE;
            dt_cnt <= '0;
            cmd_q  <= 1'b0;
            PH     <= 1'b0;
            PL     <= 1'b0;
         end else if (!E) begin
            state  <= DT_IDLE;
            dt_cnt <= '0;
            PH     <= 1'b0;
            PL     <= 1'b0;
         end else begin
            unique case (state)
               DT_IDLE: begin
                  state  <= DT_WAIT;
                  dt_cnt <= DT_LOAD;
                  cmd_q  <= CMD;
                  PH     <= 1'b0;
                  PL     <= 1'b0;
               end
               DT_WAIT: begin
                  if (CMD != cmd_q) begin
                     cmd_q  <= CMD;
                     dt_cnt <= DT_LOAD;
                  end else if (dt_cnt == DTW'(1)) begin
                     state  <= DT_DRIVE;
                     dt_cnt <= '0;
                     PH     <= cmd_q;
                     PL     <= ~cmd_q;
                  end else begin
                     dt_cnt <= dt_cnt - 1'b1;
                  end
               end
               DT_DRIVE: begin
                  if (CMD != cmd_q) begin
                     state  <= DT_WAIT;
                     cmd_q  <= CMD;
                     dt_cnt <= DT_LOAD;
                     PH     <= 1'b0;
                     PL     <= 1'b0;
                  end
               end
               default: begin
                  state <= DT_IDLE;
                  PH    <= 1'b0;
                  PL    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/pwm_gen_n.sv
// N-channel PWM generator: shared period counter, double-buffered duty,
// saturation flags, period strobe and per-channel dead-time drivers.
module pwm_gen_n import pwm_gen_n_pkg::*; #(
   parameter int N      = N_DEF,
   parameter int W      = W_DEF,
   parameter int PERIOD = PERIOD_DEF,
   parameter int DT     = DT_DEF
) (
   input logic        CLK,
   input logic        RST_N,
   pwm_gen_n_if.slave bus
);

   if (!period_ok(PERIOD, W)) begin : g_bad_period
      $error("pwm_gen_n: PERIOD must lie in 2..2**W");
   end
   if (!dt_ok(DT, PERIOD)) begin : g_bad_dt
      $error("pwm_gen_n: DT must lie in 0..PERIOD/2-1");
   end

   localparam logic [W-1:0] CNT_LAST = W'(PERIOD - 1);
   // One extra bit so PERIOD == 2**W is still representable.
   localparam logic [W:0]   PERIOD_X = (W + 1)'(PERIOD);

   logic [W-1:0]         cnt;
   logic                 e_q;
   logic                 ps;
   logic                 wrap;
   logic                 load_act;
   logic [N-1:0][W-1:0]  shadow;
   logic [N-1:0][W-1:0]  active;
   logic [N-1:0][W-1:0]  active_nxt;
   logic [N-1:0]         x;
   logic [N-1:0]         x_nxt;
   logic [N-1:0]         cmd;
   logic [N-1:0]         ph;
   logic [N-1:0]         pl;

   assign wrap     = bus.E && (cnt == CNT_LAST);
   // Active duty follows the shadow at wrap and on the first enabled cycle.
   assign load_act = bus.E && (wrap || !e_q);

   // Next active duty; a coincident load strobe bypasses the shadow.
   always_comb begin
      active_nxt = active;
      if (load_act) active_nxt = bus.LD ? bus.D : shadow;
      for (int i = 0; i < N; i++) begin
         x_nxt[i] = ({1'b0, active_nxt[i]} >= PERIOD_X);
      end
   end

   // Period counter, enable history and wrap strobe.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
         e_q <= 1'b0;
         ps  <= 1'b0;
      end else begin
         e_q <= bus.E;
         ps  <= wrap;
         if (!bus.E || wrap) cnt <= '0;
         else                cnt <= cnt + 1'b1;
      end
   end

   // Duty double buffer and saturation flags.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         shadow <= '0;
         active <= '0;
         x      <= '0;
      end else begin
         if (bus.LD) shadow <= bus.D;
         active <= active_nxt;
         x      <= x_nxt;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign cmd[i] = (cnt < active[i]);

      pwm_gen_n_deadtime #(.DT(DT)) u_dt (
         .CLK   (CLK),
         .RST_N (RST_N),
         .E     (bus.E),
         .CMD   (cmd[i]),
         .PH    (ph[i]),
         .PL    (pl[i])
      );
   end

   assign bus.CNT = cnt;
   assign bus.PS  = ps;
   assign bus.X   = x;
   assign bus.PH  = ph;
   assign bus.PL  = pl;

endmodule

// File: tb/tb_pwm_gen_n.sv
// Bench for pwm_gen_n: one DT=4 and one DT=0 instance share stimulus and are
// checked every cycle against a behavioural model. The gate model says a gate
// is on once cmd has been stable for more than DT enabled cycles.
module tb_pwm_gen_n;
   localparam int N   = 3;
   localparam int W   = 9;
   localparam int P   = 510;
   localparam int DTA = 4;

   logic           CLK   = 1'b0;
   logic           RST_N = 1'b0;
   logic           e     = 1'b0;
   logic           ld    = 1'b0;
   logic [N*W-1:0] d     = '0;

   int checks = 0;
   int errors = 0;

   int m_cnt;
   bit m_eq;
   bit m_ps;
   int m_shadow [N];
   int m_active [N];
   int m_age    [N];
   bit m_cmdp   [N];
   bit m_ph     [2][N];
   bit m_pl     [2][N];

   always #5 CLK = ~CLK;

   pwm_gen_n_if #(.N(N), .W(W)) bus_a ();
   pwm_gen_n_if #(.N(N), .W(W)) bus_b ();

   assign bus_a.E  = e;
   assign bus_a.LD = ld;
   assign bus_a.D  = d;
   assign bus_b.E  = e;
   assign bus_b.LD = ld;
   assign bus_b.D  = d;

   pwm_gen_n #(.N(N), .W(W), .PERIOD(P), .DT(DTA)) dut_a (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus_a)
   );

   pwm_gen_n #(.N(N), .W(W), .PERIOD(P), .DT(0)) dut_b (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
         if (errors >= 40) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_eq  = 1'b0;
      m_ps  = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_shadow[i] = 0;
         m_active[i] = 0;
         m_age[i]    = 0;
         m_cmdp[i]   = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_ph[k][i] = 1'b0;
            m_pl[k][i] = 1'b0;
         end
      end
   endtask

   task automatic compare();
      logic [N-1:0] ex, epha, epla, ephb, eplb;
      for (int i = 0; i < N; i++) begin
         ex[i]   = (m_active[i] >= P);
         epha[i] = m_ph[0][i];
         epla[i] = m_pl[0][i];
         ephb[i] = m_ph[1][i];
         eplb[i] = m_pl[1][i];
      end
      chk("cnt_a", bus_a.CNT, m_cnt);
      chk("cnt_b", bus_b.CNT, m_cnt);
      chk("ps_a", bus_a.PS, m_ps);
      chk("ps_b", bus_b.PS, m_ps);
      chk("x_a", bus_a.X, ex);
      chk("x_b", bus_b.X, ex);
      chk("ph_a", bus_a.PH, epha);
      chk("pl_a", bus_a.PL, epla);
      chk("ph_b", bus_b.PH, ephb);
      chk("pl_b", bus_b.PL, eplb);
      chk("excl_a", bus_a.PH & bus_a.PL, 0);
      chk("excl_b", bus_b.PH & bus_b.PL, 0);
   endtask

   // One clock: advance the model across the edge, then compare mid-cycle.
   task automatic step();
      bit cmd [N];
      bit wrap, start;
      int dtk;
      if (!RST_N) begin
         model_reset();
      end else begin
         wrap  = e && (m_cnt == P - 1);
         start = e && !m_eq;
         for (int i = 0; i < N; i++) begin
            cmd[i] = (m_cnt < m_active[i]);
            if (!e)                             m_age[i] = 0;
            else if (start || cmd[i] != m_cmdp[i]) m_age[i] = 1;
            else if (m_age[i] < 100000)         m_age[i] = m_age[i] + 1;
            m_cmdp[i] = cmd[i];
            for (int k = 0; k < 2; k++) begin
               dtk = (k == 0) ? DTA : 0;
               m_ph[k][i] = e && (m_age[i] > dtk) && cmd[i];
               m_pl[k][i] = e && (m_age[i] > dtk) && !cmd[i];
            end
            if (ld) m_shadow[i] = int'(d[i*W +: W]);
            if (wrap || start) m_active[i] = m_shadow[i];
         end
         m_ps  = wrap;
         m_cnt = (!e || wrap) ? 0 : m_cnt + 1;
         m_eq  = e;
      end
      @(posedge CLK);
      @(negedge CLK);
      compare();
   endtask

   task automatic set_duty(input int ch, input int v);
      d[ch*W +: W] = W'(v);
   endtask

   task automatic load();
      ld = 1'b1;
      step();
      ld = 1'b0;
   endtask

   task automatic run_to(input int target);
      int n = 0;
      while (m_cnt != target && n < 2 * P) begin
         step();
         n++;
      end
   endtask

   task automatic window(input int ncyc, input int ch,
                         output int c_pha, output int c_pla, output int c_phb,
                         output int c_plb, output int c_gap, output int c_ps);
      c_pha = 0; c_pla = 0; c_phb = 0; c_plb = 0; c_gap = 0; c_ps = 0;
      repeat (ncyc) begin
         step();
         c_pha += int'(bus_a.PH[ch]);
         c_pla += int'(bus_a.PL[ch]);
         c_phb += int'(bus_b.PH[ch]);
         c_plb += int'(bus_b.PL[ch]);
         c_gap += int'(!bus_a.PH[ch] && !bus_a.PL[ch]);
         c_ps  += int'(bus_a.PS);
      end
   endtask

   // Reset dropped between edges must clear everything with no clock.
   task automatic async_rst();
      #2 RST_N = 1'b0;
      #1;
      chk("rst_cnt_a", bus_a.CNT, 0);
      chk("rst_ph_a", bus_a.PH, 0);
      chk("rst_pl_a", bus_a.PL, 0);
      chk("rst_x_a", bus_a.X, 0);
      chk("rst_ps_a", bus_a.PS, 0);
      chk("rst_ph_b", bus_b.PH, 0);
      chk("rst_pl_b", bus_b.PL, 0);
      chk("rst_cnt_b", bus_b.CNT, 0);
      e  = 1'b0;
      ld = 1'b0;
      model_reset();
      repeat (2) step();
      RST_N = 1'b1;
      repeat (3) step();
   endtask

   function automatic int rnd_duty();
      case ($urandom_range(0, 7))
         0:       return 0;
         1:       return 1;
         2:       return 2;
         3:       return P - 1;
         4:       return P;
         5:       return 511;
         default: return int'($urandom_range(0, P - 1));
      endcase
   endfunction

   initial begin
      int a_ph, a_pl, b_ph, b_pl, gap, psn, n, cnt_ph_b;

      model_reset();
      repeat (3) step();
      RST_N = 1'b1;
      repeat (4) step();

      // Basic duties, both instances
      set_duty(0, 100);
      set_duty(1, 255);
      set_duty(2, 0);
      load();
      e = 1'b1;
      repeat (20) step();
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t2_ph_b0", b_ph, 100);
      chk("t2_ph_a0", a_ph, 96);
      chk("t2_pl_a0", a_pl, 406);
      chk("t2_gap_a0", gap, 8);
      chk("t2_ps", psn, 1);
      window(P, 1, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t2_ph_b1", b_ph, 255);
      chk("t2_ph_a1", a_ph, 251);
      window(P, 2, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t2_pl_b2", b_pl, P);
      chk("t2_ph_b2", b_ph, 0);

      // Asynchronous reset mid-period
      run_to(50);
      chk("t1_ph_pre", bus_b.PH[0], 1);
      async_rst();
      load();
      e = 1'b1;
      repeat (5) step();

      // Double buffer: second load before the wrap wins
      run_to(0);
      cnt_ph_b = 0;
      for (int k = 0; k < P; k++) begin
         if (m_cnt == 200) begin
            set_duty(0, 300);
            ld = 1'b1;
         end else if (m_cnt == 250) begin
            set_duty(0, 180);
            ld = 1'b1;
         end else begin
            ld = 1'b0;
         end
         step();
         cnt_ph_b += int'(bus_b.PH[0]);
      end
      ld = 1'b0;
      chk("t3_cur_period", cnt_ph_b, 100);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t3_next_b", b_ph, 180);
      chk("t3_next_a", a_ph, 176);

      // Saturation
      set_duty(0, 510);
      load();
      run_to(0);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t5_sat_ph_a", a_ph, P);
      chk("t5_sat_pl_a", a_pl, 0);
      chk("t5_sat_ph_b", b_ph, P);
      chk("t5_sat_x", bus_a.X[0], 1);
      set_duty(0, 511);
      load();
      run_to(0);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t5_511_ph_a", a_ph, P);
      chk("t5_511_gap", gap, 0);
      set_duty(0, 509);
      load();
      run_to(0);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t5_509_ph_a", a_ph, 505);
      chk("t5_509_pl_a", a_pl, 0);
      chk("t5_509_gap", gap, 5);
      chk("t5_509_ph_b", b_ph, 509);
      chk("t5_509_pl_b", b_pl, 1);
      chk("t5_509_x", bus_a.X[0], 0);

      // Short pulse swallowed by dead time
      set_duty(0, 2);
      load();
      run_to(0);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      window(P, 0, a_ph, a_pl, b_ph, b_pl, gap, psn);
      chk("t6_ph_a", a_ph, 0);
      chk("t6_pl_a", a_pl, P - 6);
      chk("t6_ph_b", b_ph, 2);

      // Enable dropout and safe restart
      run_to(123);
      e = 1'b0;
      repeat (3) step();
      chk("t6_off_cnt", bus_a.CNT, 0);
      chk("t6_off_gates", bus_a.PH | bus_a.PL, 0);
      e = 1'b1;
      step();
      chk("t6_b_start", bus_b.PL[2], 1);
      n = 0;
      while (bus_a.PL[2] == 1'b0 && n < 20) begin
         n++;
         step();
      end
      chk("t6_safe_start", n, DTA);

      // Randomised operation
      for (int it = 0; it < 50; it++) begin
         int sel;
         for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(0, 2) != 0) set_duty(ch, rnd_duty());
         end
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      async_rst();
         else if (sel <= 2) e = ~e;
         if ($urandom_range(0, 1) != 0) load();
         if (!e && $urandom_range(0, 3) != 0) e = 1'b1;
         repeat ($urandom_range(1, 700)) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
